interface_dht11_multi_uc: RTL and testbench
===========================================

# interface_dht11_multi_uc

Control unit for a multi-sensor DHT11 acquisition path. It sweeps `N_CH` sensors in order: for each channel it issues a start pulse, times the post-start delay internally, waits for the reception datapath to report, and retries on a bad checksum or a timeout. Per-channel load strobes and sticky error flags go to the measurement register bank. A continuous mode re-arms the sweep after a programmable pause. It sits between the top-level measure request and the shared DHT11 serial receiver datapath.

## Interface
- `N_CH`, 4: number of sensors swept; ≥1.
- `DELAY_CYCLES`, 50: cycles spent in the post-start delay; ≥1.
- `TIMEOUT_CYCLES`, 1000: maximum cycles waiting for `fim_recepcao_medida`; ≥1.
- `MAX_TENTATIVAS`, 3: attempts per channel before it is declared failed; ≥1.
- `PAUSA_CYCLES`, 500: idle cycles between sweeps in continuous mode; ≥1.
- Derived: `CW = max(1, $clog2(N_CH))`; `TW = max(1, $clog2(MAX_TENTATIVAS))`.

Ports:
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low. The `reset` port is active-low.
- `medir_dht11` in 1: starts a sweep when sampled high in INICIAL.
- `modo_continuo` in 1: 1 = re-sweep after the pause; 0 = single sweep.
- `fim_recepcao_medida` in 1: receiver finished a frame; valid only in ESPERA_MEDIDA.
- `medida_ok` in 1: checksum good; qualified by `fim_recepcao_medida`.
- `canal` out CW: channel currently addressed; drives the sensor mux.
- `medir_out` out 1: one-cycle start pulse to the receiver/driver.
- `load_medida` out N_CH: one-hot, one-cycle load strobe for register bank `canal`.
- `erro_canal` out N_CH: sticky failure flags for the current/last sweep.
- `pronto_medida` out 1: one-cycle pulse at end of sweep.
- `ocupado` out 1: high whenever the state is not INICIAL.
- `db_estado` out 4: state encoding.
- `db_tentativas` out TW: attempt index of the current channel.

## Operation
- Registers: state; `canal`; attempt counter `tent`; one shared cycle counter `cnt` sized for max(DELAY, TIMEOUT, PAUSA); `erro_canal`.
- States and `db_estado` encodings:
  - INICIAL 0: on `medir_dht11`=1 → MEDE. In the same transition, clear `canal`, `tent` and `erro_canal`.
  - MEDE 1: `medir_out`=1 and `cnt`←0 → ESPERA_DELAY.
  - ESPERA_DELAY 2: `cnt`++. When `cnt`==DELAY_CYCLES-1 → ESPERA_MEDIDA with `cnt`←0.
  - ESPERA_MEDIDA 3: `cnt`++. Exits are:
    - `fim_recepcao_medida`=1 with `medida_ok`=1 → ARMAZENA.
    - `fim_recepcao_medida`=1 with `medida_ok`=0 → retry.
    - Otherwise, when `cnt`==TIMEOUT_CYCLES-1 → retry.
  - Retry rule: if `tent`==MAX_TENTATIVAS-1 → FALHA; else `tent`++ → MEDE.
  - ARMAZENA 4: `load_medida[canal]`=1 → PROXIMO.
  - FALHA 5: `erro_canal[canal]`←1 → PROXIMO.
  - PROXIMO 6: if `canal`==N_CH-1 → FIM; else `canal`++, `tent`←0 → MEDE.
  - FIM 7: `pronto_medida`=1. → PAUSA if `modo_continuo`, else INICIAL; `cnt`←0.
  - PAUSA 8: `cnt`++. Exits are:
    - `modo_continuo`=0 → INICIAL.
    - `cnt`==PAUSA_CYCLES-1 → MEDE, with `canal`, `tent` and `erro_canal` cleared.
  - Unused encodings → INICIAL.
- `medir_dht11` is ignored outside INICIAL.
- `fim_recepcao_medida` is ignored outside ESPERA_MEDIDA.
- `erro_canal` holds its value from FIM until the next sweep starts.
- `medir_out`, `load_medida` and `pronto_medida` are Moore outputs decoded from the state; they are glitch-free at the register level.

## Timing
- Reset (`reset`=0, async): state=INICIAL. All outputs 0, including `canal`, `erro_canal`, `db_tentativas` and `db_estado`. Reset mid-sweep aborts immediately and no strobe is emitted.
- Durations: ESPERA_DELAY lasts exactly DELAY_CYCLES cycles. PAUSA lasts exactly PAUSA_CYCLES cycles unless `modo_continuo` drops.
- Timeout: with no response, ESPERA_MEDIDA lasts exactly TIMEOUT_CYCLES cycles.
- Simultaneous events: `fim_recepcao_medida` and the timeout in the same cycle → `fim_recepcao_medida` wins.
- Per-channel first-try success, with `fim_recepcao_medida` in the k-th cycle of ESPERA_MEDIDA: the channel takes 1+DELAY+k+1+1 cycles, MEDE through PROXIMO.
- Sweep end: `pronto_medida` occurs one cycle after the last PROXIMO.
- Latency from start: `medir_dht11` sampled at edge t → `medir_out` high in cycle t+1.
- Failed channel: the channel consumes MAX_TENTATIVAS full attempts, then 2 cycles (FALHA, PROXIMO).
- N_CH=1: PROXIMO goes straight to FIM; `canal` stays 0.

## Test plan
Parameters for all scenarios: N_CH=2, DELAY=3, TIMEOUT=8, MAX_TENTATIVAS=2, PAUSA=5.
- Reset: pulse `reset` low. All outputs read 0 and `db_estado`=0. Drive `medir_dht11`=1 during reset → no `medir_out`.
- Clean single sweep: `medida_ok`=1, `fim_recepcao_medida` in the 2nd ESPERA_MEDIDA cycle. Required:
  - exactly 2 `medir_out` pulses;
  - `load_medida`=01 then 10, 8 cycles apart;
  - 3 cycles between `medir_out` and ESPERA_MEDIDA;
  - one `pronto_medida` pulse; `erro_canal`=00.
- Retry: ch0 first response `medida_ok`=0, second response ok. Required: 3 `medir_out` pulses total; `db_tentativas`=1 during the ch0 second attempt; `erro_canal`=00.
- Timeout/failure: ch1 never responds. Required: two 8-cycle ESPERA_MEDIDA windows; `erro_canal`=10; only `load_medida`=01 seen; `pronto_medida` still pulses. Also drive `fim_recepcao_medida` on the timeout cycle → result counts as a response.
- Continuous: `modo_continuo`=1 → after FIM, 5 PAUSA cycles, then `medir_out` with `canal`=0 and `erro_canal` cleared. Drop `modo_continuo` mid-PAUSA → INICIAL next cycle.
- Abort: assert `reset` low in the 4th cycle of ESPERA_MEDIDA. Required: all outputs 0 before the next edge; no `load_medida`; the next `medir_dht11` restarts at `canal`=0.

Source files
------------

// File: rtl/interface_dht11_multi_uc.sv
// interface_dht11_multi_uc: sweep controller for N_CH DHT11 sensors with per-channel retry,
// timeout and continuous re-arm. Rev 1.0
`default_nettype none

module interface_dht11_multi_uc #(
  parameter  int N_CH           = 4,
  parameter  int DELAY_CYCLES   = 50,
  parameter  int TIMEOUT_CYCLES = 1000,
  parameter  int MAX_TENTATIVAS = 3,
  parameter  int PAUSA_CYCLES   = 500,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int TW = (MAX_TENTATIVAS > 1) ? $clog2(MAX_TENTATIVAS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            medir_dht11,
  input  logic            modo_continuo,
  input  logic            fim_recepcao_medida,
  input  logic            medida_ok,
  output logic [CW-1:0]   canal,
  output logic            medir_out,
  output logic [N_CH-1:0] load_medida,
  output logic [N_CH-1:0] erro_canal,
  output logic            pronto_medida,
  output logic            ocupado,
  output logic [3:0]      db_estado,
  output logic [TW-1:0]   db_tentativas
);

  localparam int MAX_DT  = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_ALL = (MAX_DT > PAUSA_CYCLES) ? MAX_DT : PAUSA_CYCLES;
  localparam int NW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [NW-1:0] DELAY_LAST   = NW'(DELAY_CYCLES - 1);
  localparam logic [NW-1:0] TIMEOUT_LAST = NW'(TIMEOUT_CYCLES - 1);
  localparam logic [NW-1:0] PAUSA_LAST   = NW'(PAUSA_CYCLES - 1);
  localparam logic [CW-1:0] CANAL_LAST   = CW'(N_CH - 1);
  localparam logic [TW-1:0] TENT_LAST    = TW'(MAX_TENTATIVAS - 1);

  localparam logic [3:0] S_INICIAL       = 4'd0;
  localparam logic [3:0] S_MEDE          = 4'd1;
  localparam logic [3:0] S_ESPERA_DELAY  = 4'd2;
  localparam logic [3:0] S_ESPERA_MEDIDA = 4'd3;
  localparam logic [3:0] S_ARMAZENA      = 4'd4;
  localparam logic [3:0] S_FALHA         = 4'd5;
  localparam logic [3:0] S_PROXIMO       = 4'd6;
  localparam logic [3:0] S_FIM           = 4'd7;
  localparam logic [3:0] S_PAUSA         = 4'd8;

  logic [3:0]    state;
  logic [3:0]    next_state;
  logic [TW-1:0] tent;
  logic [NW-1:0] cnt;

  logic delay_done;
  logic timeout_hit;
  logic pausa_done;
  logic resp_good;
  logic attempt_failed;
  logic last_try;
  logic last_canal;

  assign delay_done  = (cnt == DELAY_LAST);
  assign timeout_hit = (cnt == TIMEOUT_LAST);
  assign pausa_done  = (cnt == PAUSA_LAST);
  assign last_try    = (tent == TENT_LAST);
  assign last_canal  = (canal == CANAL_LAST);
  assign resp_good   = fim_recepcao_medida & medida_ok;
  // A frame arriving on the timeout cycle is a response, not a timeout.
  assign attempt_failed = fim_recepcao_medida ? ~medida_ok : timeout_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_INICIAL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INICIAL:       if (medir_dht11) next_state = S_MEDE;
      S_MEDE:          next_state = S_ESPERA_DELAY;
      S_ESPERA_DELAY:  if (delay_done) next_state = S_ESPERA_MEDIDA;
      S_ESPERA_MEDIDA: begin
        if (resp_good) begin
          next_state = S_ARMAZENA;
        end else if (attempt_failed) begin
          next_state = last_try ? S_FALHA : S_MEDE;
        end
      end
      S_ARMAZENA:      next_state = S_PROXIMO;
      S_FALHA:         next_state = S_PROXIMO;
      S_PROXIMO:       next_state = last_canal ? S_FIM : S_MEDE;
      S_FIM:           next_state = modo_continuo ? S_PAUSA : S_INICIAL;
      S_PAUSA: begin
        if (!modo_continuo) begin
          next_state = S_INICIAL;
        end else if (pausa_done) begin
          next_state = S_MEDE;
        end
      end
      default:         next_state = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      canal      <= '0;
      tent       <= '0;
      cnt        <= '0;
      erro_canal <= '0;
    end else begin
      case (state)
        S_INICIAL: begin
          if (medir_dht11) begin
            canal      <= '0;
            tent       <= '0;
            erro_canal <= '0;
          end
        end
        S_MEDE: cnt <= '0;
        S_ESPERA_DELAY: cnt <= delay_done ? '0 : cnt + NW'(1);
        S_ESPERA_MEDIDA: begin
          cnt <= cnt + NW'(1);
          if (!resp_good && attempt_failed && !last_try) begin
            tent <= tent + TW'(1);
          end
        end
        S_FALHA: erro_canal[canal] <= 1'b1;
        S_PROXIMO: begin
          if (!last_canal) begin
            canal <= canal + CW'(1);
            tent  <= '0;
          end
        end
        S_FIM: cnt <= '0;
        S_PAUSA: begin
          cnt <= cnt + NW'(1);
          if (modo_continuo && pausa_done) begin
            canal      <= '0;
            tent       <= '0;
            erro_canal <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    medir_out     = (state == S_MEDE);
    pronto_medida = (state == S_FIM);
    ocupado       = (state != S_INICIAL);
    db_estado     = state;
    db_tentativas = tent;
    load_medida   = '0;
    if (state == S_ARMAZENA) begin
      load_medida[canal] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interface_dht11_multi_uc.sv
// tb_interface_dht11_multi_uc: randomized sweep scenarios against a segment-level timeline model.
`default_nettype none

module tb_interface_dht11_multi_uc;

  localparam int NCH  = 2;
  localparam int DLY  = 3;
  localparam int TMO  = 8;
  localparam int MAXT = 2;
  localparam int PAU  = 5;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int VW   = 4 + 1 + NCH + 1 + 1 + NCH + CW + TW;

  localparam logic [3:0] E_INI = 4'd0, E_MEDE = 4'd1, E_DLY = 4'd2, E_MED = 4'd3, E_ARM = 4'd4,
                         E_FAL = 4'd5, E_PRX = 4'd6, E_FIM = 4'd7, E_PAU = 4'd8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic medir_dht11 = 1'b0;
  logic modo_continuo = 1'b0;
  logic fim_recepcao_medida = 1'b0;
  logic medida_ok = 1'b0;
  logic [CW-1:0]  canal;
  logic           medir_out;
  logic [NCH-1:0] load_medida;
  logic [NCH-1:0] erro_canal;
  logic           pronto_medida;
  logic           ocupado;
  logic [3:0]     db_estado;
  logic [TW-1:0]  db_tentativas;

  interface_dht11_multi_uc #(
    .N_CH(NCH), .DELAY_CYCLES(DLY), .TIMEOUT_CYCLES(TMO), .MAX_TENTATIVAS(MAXT), .PAUSA_CYCLES(PAU)
  ) dut (
    .clock(clock), .reset(reset), .medir_dht11(medir_dht11), .modo_continuo(modo_continuo),
    .fim_recepcao_medida(fim_recepcao_medida), .medida_ok(medida_ok), .canal(canal),
    .medir_out(medir_out), .load_medida(load_medida), .erro_canal(erro_canal),
    .pronto_medida(pronto_medida), .ocupado(ocupado), .db_estado(db_estado),
    .db_tentativas(db_tentativas)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]     st;
    logic           med, fim, ok, modo;
    int             canal, tent;
    logic [NCH-1:0] erro;
  } rec_t;

  typedef struct {
    logic [3:0]     st;
    logic           medir, pronto, ocup;
    logic [NCH-1:0] load, erro;
    logic [CW-1:0]  canal;
    logic [TW-1:0]  tent;
  } obs_t;

  rec_t exp_q[$];
  obs_t obs_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_canal = 0;
  int m_tent = 0;
  logic [NCH-1:0] m_erro = '0;
  int resp_k [NCH][MAXT];
  bit resp_ok [NCH][MAXT];

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic logic [VW-1:0] exp_vec(input rec_t r);
    logic [NCH-1:0] ld;
    ld = '0;
    if (r.st == E_ARM) ld[r.canal] = 1'b1;
    return {r.st, r.st == E_MEDE, ld, r.st == E_FIM, r.st != E_INI, r.erro, CW'(r.canal), TW'(r.tent)};
  endfunction

  function automatic logic [VW-1:0] obs_vec(input obs_t o);
    return {o.st, o.medir, o.load, o.pronto, o.ocup, o.erro, o.canal, o.tent};
  endfunction

  function automatic logic [VW-1:0] cur_vec();
    return {db_estado, medir_out, load_medida, pronto_medida, ocupado, erro_canal, canal, db_tentativas};
  endfunction

  // Model: one record per clock cycle, built from segment lengths of each attempt.
  task automatic push(input logic [3:0] st, input logic fim_v, input logic ok_v,
                      input logic med_v, input logic modo_v);
    rec_t r;
    r.st = st; r.fim = fim_v; r.ok = ok_v; r.med = med_v; r.modo = modo_v;
    r.canal = m_canal; r.tent = m_tent; r.erro = m_erro;
    exp_q.push_back(r);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) push(E_INI, rb(), rb(), 1'b0, rb());
  endtask

  task automatic gen_sweep(input bit from_idle, input bit modo_end);
    int k, len;
    bit good;
    if (from_idle) push(E_INI, rb(), rb(), 1'b1, rb());
    m_canal = 0; m_tent = 0; m_erro = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_canal = ch;
      for (int a = 0; a < MAXT; a++) begin
        m_tent = a;
        push(E_MEDE, rb(), rb(), rb(), rb());
        for (int d = 0; d < DLY; d++) push(E_DLY, rb(), rb(), rb(), rb());
        k = resp_k[ch][a];
        len = (k >= 1 && k <= TMO) ? k : TMO;
        for (int j = 1; j <= len; j++) begin
          if (j == k) push(E_MED, 1'b1, resp_ok[ch][a], rb(), rb());
          else        push(E_MED, 1'b0, rb(), rb(), rb());
        end
        good = (k >= 1 && k <= TMO) && resp_ok[ch][a];
        if (good) begin
          push(E_ARM, rb(), rb(), rb(), rb());
          push(E_PRX, rb(), rb(), rb(), rb());
          break;
        end
        if (a == MAXT - 1) begin
          push(E_FAL, rb(), rb(), rb(), rb());
          m_erro[ch] = 1'b1;
          push(E_PRX, rb(), rb(), rb(), rb());
        end
      end
    end
    push(E_FIM, rb(), rb(), rb(), modo_end);
  endtask

  task automatic gen_pause(input int drop_at);
    for (int j = 0; j < PAU; j++) begin
      if (j == drop_at) begin
        push(E_PAU, rb(), rb(), rb(), 1'b0);
        return;
      end
      push(E_PAU, rb(), rb(), rb(), 1'b1);
    end
  endtask

  task automatic plan_all(input int k, input bit ok);
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < MAXT; a++) begin
        resp_k[c][a] = k; resp_ok[c][a] = ok;
      end
  endtask

  task automatic play(input int n);
    obs_t o;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      medir_dht11 = exp_q[i].med;
      fim_recepcao_medida = exp_q[i].fim;
      medida_ok = exp_q[i].ok;
      modo_continuo = exp_q[i].modo;
      @(negedge clock);
      o.st = db_estado; o.medir = medir_out; o.pronto = pronto_medida; o.ocup = ocupado;
      o.load = load_medida; o.erro = erro_canal; o.canal = canal; o.tent = db_tentativas;
      obs_q.push_back(o);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    medir_dht11 = 1'b1;
    #1;
    n_cmp++;
    if (cur_vec() !== '0) begin
      n_err++; $display("FAIL reset_async: got %h expected 0", cur_vec());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if (cur_vec() !== '0 || medir_out !== 1'b0) begin
        n_err++; $display("FAIL reset_hold cyc %0d: got %h expected 0", i, cur_vec());
      end
    end
    medir_dht11 = 1'b0;
    reset = 1'b1;
    m_canal = 0; m_tent = 0; m_erro = '0;
  endtask

  task automatic test_clean_sweep();
    int nm, cm, ce, l0, l1, np, shown;
    exp_q.delete();
    plan_all(2, 1'b1);
    gen_sweep(1'b1, 1'b0);
    gen_idle(2);
    play(exp_q.size());
    shown = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
        n_err++;
        if (shown++ < 8) $display("FAIL clean_trace cyc %0d: got %h expected %h", i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
      end
    end
    nm = 0; cm = -1; ce = -1; l0 = -1; l1 = -1; np = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].medir) begin nm++; if (cm < 0) cm = i; end
      if (obs_q[i].st == E_MED && ce < 0) ce = i;
      if (obs_q[i].load == 2'b01 && l0 < 0) l0 = i;
      if (obs_q[i].load == 2'b10 && l1 < 0) l1 = i;
      if (obs_q[i].pronto) np++;
    end
    n_cmp++;
    if (nm !== 2) begin n_err++; $display("FAIL clean_medir_count: got %0d expected 2", nm); end
    n_cmp++;
    if (l0 < 0 || l1 - l0 !== 1 + DLY + 2 + 1 + 1) begin
      n_err++; $display("FAIL clean_load_gap: got %0d expected %0d", l1 - l0, 1 + DLY + 2 + 1 + 1);
    end
    n_cmp++;
    if (ce - cm - 1 !== DLY) begin n_err++; $display("FAIL clean_delay: got %0d expected %0d", ce - cm - 1, DLY); end
    n_cmp++;
    if (np !== 1) begin n_err++; $display("FAIL clean_pronto_count: got %0d expected 1", np); end
    n_cmp++;
    if (obs_q[obs_q.size()-1].erro !== 2'b00) begin
      n_err++; $display("FAIL clean_erro: got %b expected 00", obs_q[obs_q.size()-1].erro);
    end
  endtask

  task automatic test_retry();
    int nm, t2, shown;
    exp_q.delete();
    plan_all($urandom_range(1, TMO), 1'b1);
    resp_k[0][0] = $urandom_range(1, TMO); resp_ok[0][0] = 1'b0;
    resp_k[0][1] = $urandom_range(1, TMO); resp_ok[0][1] = 1'b1;
    gen_sweep(1'b1, 1'b0);
    gen_idle(2);
    play(exp_q.size());
    shown = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
        n_err++;
        if (shown++ < 8) $display("FAIL retry_trace cyc %0d: got %h expected %h", i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
      end
    end
    nm = 0; t2 = -1;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].medir) begin
        nm++;
        if (nm == 2) t2 = int'(obs_q[i].tent);
      end
    n_cmp++;
    if (nm !== 3) begin n_err++; $display("FAIL retry_medir_count: got %0d expected 3", nm); end
    n_cmp++;
    if (t2 !== 1) begin n_err++; $display("FAIL retry_tentativas: got %0d expected 1", t2); end
    n_cmp++;
    if (obs_q[obs_q.size()-1].erro !== 2'b00) begin
      n_err++; $display("FAIL retry_erro: got %b expected 00", obs_q[obs_q.size()-1].erro);
    end
  endtask

  task automatic test_timeout();
    int run, nwin, badlen, nload, np, nm, shown;
    logic seen10;
    exp_q.delete();
    plan_all($urandom_range(1, TMO), 1'b1);
    resp_k[1][0] = 0; resp_k[1][1] = 0;
    gen_sweep(1'b1, 1'b0);
    gen_idle(2);
    play(exp_q.size());
    shown = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
        n_err++;
        if (shown++ < 8) $display("FAIL timeout_trace cyc %0d: got %h expected %h", i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
      end
    end
    run = 0; nwin = 0; badlen = 0; nload = 0; np = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].st == E_MED && obs_q[i].canal == 1'b1) run++;
      else if (run != 0) begin
        nwin++; if (run != TMO) badlen++; run = 0;
      end
      if (obs_q[i].load != '0) begin
        nload++; if (obs_q[i].load != 2'b01) badlen++;
      end
      if (obs_q[i].pronto) np++;
    end
    n_cmp++;
    if (nwin !== 2 || badlen !== 0) begin
      n_err++; $display("FAIL timeout_windows: got %0d windows (%0d bad) expected 2 of %0d", nwin, badlen, TMO);
    end
    n_cmp++;
    if (nload !== 1) begin n_err++; $display("FAIL timeout_loads: got %0d expected 1", nload); end
    n_cmp++;
    if (np !== 1) begin n_err++; $display("FAIL timeout_pronto: got %0d expected 1", np); end
    n_cmp++;
    if (obs_q[obs_q.size()-1].erro !== 2'b10) begin
      n_err++; $display("FAIL timeout_erro: got %b expected 10", obs_q[obs_q.size()-1].erro);
    end
    // response landing on the timeout cycle
    exp_q.delete();
    plan_all($urandom_range(1, TMO), 1'b1);
    resp_k[1][0] = TMO; resp_ok[1][0] = 1'b1;
    gen_sweep(1'b1, 1'b0);
    gen_idle(2);
    play(exp_q.size());
    shown = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
        n_err++;
        if (shown++ < 8) $display("FAIL edge_trace cyc %0d: got %h expected %h", i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
      end
    end
    nm = 0; seen10 = 1'b0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].medir) nm++;
      if (obs_q[i].load == 2'b10) seen10 = 1'b1;
    end
    n_cmp++;
    if (nm !== 2 || seen10 !== 1'b1) begin
      n_err++; $display("FAIL edge_response: got %0d medir, load10=%b expected 2, 1", nm, seen10);
    end
    n_cmp++;
    if (obs_q[obs_q.size()-1].erro !== 2'b00) begin
      n_err++; $display("FAIL edge_erro: got %b expected 00", obs_q[obs_q.size()-1].erro);
    end
  endtask

  task automatic test_continuous();
    int idx_p, idx_s, idx_d, d, np, shown;
    exp_q.delete();
    plan_all($urandom_range(1, TMO), 1'b1);
    resp_k[1][0] = 0; resp_k[1][1] = 0;
    gen_sweep(1'b1, 1'b1);
    idx_p = exp_q.size();
    gen_pause(-1);
    idx_s = exp_q.size();
    plan_all($urandom_range(1, TMO), 1'b1);
    gen_sweep(1'b0, 1'b1);
    d = $urandom_range(0, PAU - 2);
    idx_d = exp_q.size() + d;
    gen_pause(d);
    gen_idle(2);
    play(exp_q.size());
    shown = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
        n_err++;
        if (shown++ < 8) $display("FAIL cont_trace cyc %0d: got %h expected %h", i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
      end
    end
    np = 0;
    for (int i = idx_p; i < obs_q.size() && obs_q[i].st == E_PAU; i++) np++;
    n_cmp++;
    if (np !== PAU) begin n_err++; $display("FAIL cont_pause_len: got %0d expected %0d", np, PAU); end
    n_cmp++;
    if (obs_q[idx_s-1].erro !== 2'b10) begin
      n_err++; $display("FAIL cont_erro_held: got %b expected 10", obs_q[idx_s-1].erro);
    end
    n_cmp++;
    if (obs_q[idx_s].st !== E_MEDE || obs_q[idx_s].canal !== '0 || obs_q[idx_s].erro !== '0) begin
      n_err++; $display("FAIL cont_restart: got st=%0d canal=%0d erro=%b expected 1 0 00",
                        obs_q[idx_s].st, obs_q[idx_s].canal, obs_q[idx_s].erro);
    end
    n_cmp++;
    if (obs_q[idx_d+1].st !== E_INI) begin
      n_err++; $display("FAIL cont_drop: got st=%0d expected 0", obs_q[idx_d+1].st);
    end
  endtask

  task automatic test_abort();
    int idx, nmed, firstc, shown;
    exp_q.delete();
    plan_all(0, 1'b0);
    gen_sweep(1'b1, 1'b0);
    idx = -1; nmed = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].st == E_MED) begin
        nmed++;
        if (nmed == 4 && idx < 0) idx = i;
      end
    play(idx + 1);
    n_cmp++;
    if (obs_q[idx].st !== E_MED) begin
      n_err++; $display("FAIL abort_setup: got st=%0d expected 3", obs_q[idx].st);
    end
    #2 reset = 1'b0;
    medir_dht11 = 1'b0; fim_recepcao_medida = 1'b0;
    #1;
    n_cmp++;
    if (cur_vec() !== '0) begin n_err++; $display("FAIL abort_async: got %h expected 0", cur_vec()); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if (cur_vec() !== '0 || load_medida !== '0) begin
        n_err++; $display("FAIL abort_hold cyc %0d: got %h expected 0", i, cur_vec());
      end
    end
    reset = 1'b1;
    m_canal = 0; m_tent = 0; m_erro = '0;
    exp_q.delete();
    plan_all($urandom_range(1, TMO), 1'b1);
    gen_sweep(1'b1, 1'b0);
    gen_idle(1);
    play(exp_q.size());
    shown = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
        n_err++;
        if (shown++ < 8) $display("FAIL abort_trace cyc %0d: got %h expected %h", i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
      end
    end
    firstc = -1;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].medir && firstc < 0) firstc = int'(obs_q[i].canal);
    n_cmp++;
    if (firstc !== 0) begin n_err++; $display("FAIL abort_restart_canal: got %0d expected 0", firstc); end
  endtask

  task automatic test_random();
    int nsw, shown;
    bit last, drop;
    for (int it = 0; it < 10; it++) begin
      exp_q.delete();
      nsw = $urandom_range(1, 3);
      for (int s = 0; s < nsw; s++) begin
        for (int c = 0; c < NCH; c++)
          for (int a = 0; a < MAXT; a++) begin
            resp_k[c][a]  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TMO);
            resp_ok[c][a] = ($urandom_range(0, 3) != 0);
          end
        last = (s == nsw - 1);
        drop = last && rb();
        gen_sweep(s == 0, !last || drop);
        if (!last) gen_pause(-1);
        else if (drop) gen_pause($urandom_range(0, PAU - 1));
      end
      gen_idle($urandom_range(1, 3));
      play(exp_q.size());
      shown = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_vec(obs_q[i]) !== exp_vec(exp_q[i])) begin
          n_err++;
          if (shown++ < 8) $display("FAIL random_trace it %0d cyc %0d: got %h expected %h",
                                    it, i, obs_vec(obs_q[i]), exp_vec(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_retry();
    test_timeout();
    test_continuous();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
